// File: rtl/mctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV32I controller: FSM states,
// opcode classes, immediate/ALU select codes and trap causes.
package mctrl_pkg;

    localparam int ILEN = 32;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        CL_R      = 3'd0,
        CL_I      = 3'd1,
        CL_LOAD   = 3'd2,
        CL_STORE  = 3'd3,
        CL_BRANCH = 3'd4,
        CL_ILL    = 3'd5
    } iclass_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;

    localparam logic [1:0] CAUSE_NONE         = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL      = 2'b01;
    localparam logic [1:0] CAUSE_DMEM_TIMEOUT = 2'b10;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b1000;

    typedef struct packed {
        iclass_t    iclass;
        logic [1:0] imm_sel;
        logic       alu_src_b;
        logic [3:0] alu_op;
        logic       wb_sel;
    } ctrl_t;

endpackage

// File: rtl/mctrl_if.sv
// Instruction and data memory req/ready handshake bundle.
// master = controller side, slave = memory side.
interface mctrl_if;
    import mctrl_pkg::*;

    logic            imem_req;
    logic            imem_ready;
    logic [ILEN-1:0] imem_rdata;
    logic            dmem_req;
    logic            dmem_we;
    logic            dmem_ready;

    modport master (
        output imem_req, dmem_req, dmem_we,
        input  imem_ready, imem_rdata, dmem_ready
    );

    modport slave (
        input  imem_req, dmem_req, dmem_we,
        output imem_ready, imem_rdata, dmem_ready
    );
endinterface

// File: rtl/mctrl_decode.sv
// Combinational opcode/funct decoder producing datapath control fields.
// Zero latency; no handshake.
module mctrl_decode
    import mctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       alt,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl.iclass    = CL_ILL;
        ctrl.imm_sel   = IMM_I;
        ctrl.alu_src_b = 1'b0;
        ctrl.alu_op    = ALU_ADD;
        ctrl.wb_sel    = 1'b0;
        case (opcode)
            OP_R: begin
                ctrl.iclass = CL_R;
                ctrl.alu_op = {alt, funct3};
            end
            OP_I: begin
                // only the shift-right immediates use bit 30 as the SRA/SRL select
                ctrl.iclass    = CL_I;
                ctrl.alu_src_b = 1'b1;
                ctrl.alu_op    = {alt & (funct3 == 3'b101), funct3};
            end
            OP_LOAD: begin
                ctrl.iclass    = CL_LOAD;
                ctrl.alu_src_b = 1'b1;
                ctrl.wb_sel    = 1'b1;
            end
            OP_STORE: begin
                ctrl.iclass    = CL_STORE;
                ctrl.imm_sel   = IMM_S;
                ctrl.alu_src_b = 1'b1;
            end
            OP_BRANCH: begin
                ctrl.iclass  = CL_BRANCH;
                ctrl.imm_sel = IMM_B;
                ctrl.alu_op  = ALU_SUB;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I sequencer (FETCH/DECODE/EXEC/MEM/WB/TRAP); 3-5 cycles/instr, stalls on imem/dmem ready.
// MEM waits bounded by MEM_TIMEOUT; MCTRL_PERF_CNT_EN adds cycle/instret counters.
module multicycle_controller
    import mctrl_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic            clk,
    input  logic            rst,
    mctrl_if.master         mem,
    input  logic            br_taken,
    output logic [XLEN-1:0] ir_o,
    output logic [1:0]      imm_sel,
    output logic            alu_src_b,
    output logic [3:0]      alu_op,
    output logic            pc_we,
    output logic            pc_src,
    output logic            reg_we,
    output logic            wb_sel,
    output logic            trap,
    output logic [1:0]      trap_cause
`ifdef MCTRL_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
`endif
);

    state_t      state;
    state_t      state_nxt;
    ctrl_t       ctrl;
    logic [31:0] tcnt;
    logic        tmo;

    mctrl_decode u_decode (
        .opcode (ir_o[6:0]),
        .funct3 (ir_o[14:12]),
        .alt    (ir_o[30]),
        .ctrl   (ctrl)
    );

    assign imm_sel   = ctrl.imm_sel;
    assign alu_src_b = ctrl.alu_src_b;
    assign alu_op    = ctrl.alu_op;
    assign wb_sel    = ctrl.wb_sel;
    assign trap      = (state == ST_TRAP);

    // tcnt holds the wait cycles already spent, so this is the last permitted one
    assign tmo = (MEM_TIMEOUT != 0) && (tcnt == 32'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_FETCH:  if (mem.imem_ready) state_nxt = ST_DECODE;
            ST_DECODE: state_nxt = (ctrl.iclass == CL_ILL) ? ST_TRAP : ST_EXEC;
            ST_EXEC: begin
                case (ctrl.iclass)
                    CL_LOAD, CL_STORE: state_nxt = ST_MEM;
                    CL_BRANCH:         state_nxt = ST_FETCH;
                    default:           state_nxt = ST_WB;
                endcase
            end
            ST_MEM: begin
                if (mem.dmem_ready) begin
                    state_nxt = (ctrl.iclass == CL_STORE) ? ST_FETCH : ST_WB;
                end else if (tmo) begin
                    state_nxt = ST_TRAP;
                end
            end
            ST_WB:   state_nxt = ST_FETCH;
            ST_TRAP: state_nxt = ST_TRAP;
            default: state_nxt = ST_FETCH;
        endcase
    end

    // strobes are forced low while rst is held, even though state already reads FETCH
    always_comb begin
        mem.imem_req = 1'b0;
        mem.dmem_req = 1'b0;
        mem.dmem_we  = 1'b0;
        pc_we        = 1'b0;
        pc_src       = 1'b0;
        reg_we       = 1'b0;
        if (!rst) begin
            case (state)
                ST_FETCH: mem.imem_req = 1'b1;
                ST_EXEC: begin
                    if (ctrl.iclass == CL_BRANCH) begin
                        pc_we  = 1'b1;
                        pc_src = br_taken;
                    end
                end
                ST_MEM: begin
                    mem.dmem_req = 1'b1;
                    mem.dmem_we  = (ctrl.iclass == CL_STORE);
                    pc_we        = (ctrl.iclass == CL_STORE) && mem.dmem_ready;
                end
                ST_WB: begin
                    reg_we = 1'b1;
                    pc_we  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir_o <= '0;
        end else if (state == ST_FETCH && mem.imem_ready) begin
            ir_o <= mem.imem_rdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tcnt <= '0;
        end else if (state == ST_MEM && state_nxt == ST_MEM) begin
            tcnt <= tcnt + 32'd1;
        end else begin
            tcnt <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trap_cause <= CAUSE_NONE;
        end else if (state != ST_TRAP && state_nxt == ST_TRAP) begin
            trap_cause <= (state == ST_DECODE) ? CAUSE_ILLEGAL : CAUSE_DMEM_TIMEOUT;
        end
    end

`ifdef MCTRL_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            if (state != ST_TRAP) cycle_cnt <= cycle_cnt + CNT_W'(1);
            if (pc_we)            instret_cnt <= instret_cnt + CNT_W'(1);
        end
    end
`else
    localparam int unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: table of instructions with a memory responder,
// expected records queued at fetch and compared when the instruction retires or traps.
module tb_multicycle_controller;
    import mctrl_pkg::*;

    localparam int BUDGET = 64;

    typedef struct {
        logic [31:0] instr;
        logic        br;
        int          mwait;   // dmem wait cycles before ready; -1 = never
        int          cyc;
        int          pcwe;
        int          regwe;
        int          dcyc;
        int          dwe;
        logic        pcsrc;
        logic [1:0]  imm;
        logic        srcb;
        logic [3:0]  op;
        logic        wb;
        logic        trp;
        logic [1:0]  cause;
    } vec_t;

    typedef struct {
        int          cyc;
        int          pcwe;
        int          regwe;
        int          dcyc;
        int          dwe;
        logic        pcsrc;
        logic [1:0]  imm;
        logic        srcb;
        logic [3:0]  op;
        logic [3:0]  dec_op;
        logic        wb;
        logic        trp;
        logic [1:0]  cause;
        logic        tmo;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        br_taken = 1'b0;
    logic [31:0] ir_o;
    logic [1:0]  imm_sel;
    logic        alu_src_b;
    logic [3:0]  alu_op;
    logic        pc_we, pc_src, reg_we, wb_sel, trap;
    logic [1:0]  trap_cause;
`ifdef MCTRL_PERF_CNT_EN
    logic [31:0] cycle_cnt, instret_cnt;
`endif

    int   checks = 0;
    int   errors = 0;
    vec_t sb[$];
    vec_t tbl[15];

    mctrl_if bus ();

    multicycle_controller #(.XLEN(32), .MEM_TIMEOUT(16), .CNT_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .mem        (bus),
        .br_taken   (br_taken),
        .ir_o       (ir_o),
        .imm_sel    (imm_sel),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .pc_we      (pc_we),
        .pc_src     (pc_src),
        .reg_we     (reg_we),
        .wb_sel     (wb_sel),
        .trap       (trap),
        .trap_cause (trap_cause)
`ifdef MCTRL_PERF_CNT_EN
        ,
        .cycle_cnt  (cycle_cnt),
        .instret_cnt(instret_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_instr(input vec_t v, output obs_t o);
        int mcnt;
        bit done;
        o = '{default: 0};
        mcnt = 0;
        done = 0;
        for (int c = 1; c <= BUDGET && !done; c++) begin
            @(negedge clk);
            bus.imem_ready = bus.imem_req;
            bus.imem_rdata = v.instr;
            if (bus.imem_req && c == 1) sb.push_back(v);
            if (bus.dmem_req) mcnt++;
            bus.dmem_ready = bus.dmem_req && (mcnt == v.mwait + 1);
            br_taken = v.br;
            #1;
            o.cyc = c;
            if (c == 2) o.dec_op = alu_op;
            if (bus.dmem_req) begin
                o.dcyc++;
                if (bus.dmem_we) o.dwe++;
            end
            if (reg_we) o.regwe++;
            if (pc_we) begin
                o.pcwe++;
                o.pcsrc = pc_src;
                o.imm   = imm_sel;
                o.srcb  = alu_src_b;
                o.op    = alu_op;
                o.wb    = wb_sel;
                done = 1;
            end
            if (trap) begin
                o.trp   = 1'b1;
                o.cause = trap_cause;
                done = 1;
            end
        end
        o.tmo = !done;
    endtask

    task automatic check_obs(input obs_t o);
        vec_t e;
        if (sb.size() == 0) begin
            chk("sb_nonempty", 0, 1);
            return;
        end
        e = sb.pop_front();
        chk("completed", o.tmo, 0);
        chk("cycles", o.cyc, e.cyc);
        chk("pc_we_pulses", o.pcwe, e.pcwe);
        chk("reg_we_pulses", o.regwe, e.regwe);
        chk("dmem_req_cycles", o.dcyc, e.dcyc);
        chk("dmem_we_cycles", o.dwe, e.dwe);
        chk("trap", o.trp, e.trp);
        chk("trap_cause", o.cause, e.cause);
        if (e.pcwe != 0) begin
            chk("pc_src", o.pcsrc, e.pcsrc);
            chk("imm_sel", o.imm, e.imm);
            chk("alu_src_b", o.srcb, e.srcb);
            chk("alu_op", o.op, e.op);
            chk("alu_op_decode", o.dec_op, e.op);
            chk("wb_sel", o.wb, e.wb);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.imem_ready = 1'b0;
        bus.dmem_ready = 1'b0;
        br_taken = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_strobes", {bus.imem_req, bus.dmem_req, pc_we, reg_we}, 0);
        chk("rst_trap", {trap, trap_cause}, 0);
        chk("rst_ir", ir_o, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_fetch", bus.imem_req, 1);
    endtask

    initial begin
        obs_t o;
        int   ok;
        vec_t ill, tmo_v;

        //           instr         br  wait cyc pcwe rwe dcyc dwe src imm    b  op    wb trp cause
        tbl[0]  = '{32'h00500093, 1'b0, 0,  4, 1, 1, 0, 0, 1'b0, 2'b00, 1'b1, 4'h0, 1'b0, 1'b0, 2'b00};
        tbl[1]  = '{32'h002081B3, 1'b0, 0,  4, 1, 1, 0, 0, 1'b0, 2'b00, 1'b0, 4'h0, 1'b0, 1'b0, 2'b00};
        tbl[2]  = '{32'h402081B3, 1'b0, 0,  4, 1, 1, 0, 0, 1'b0, 2'b00, 1'b0, 4'h8, 1'b0, 1'b0, 2'b00};
        tbl[3]  = '{32'h4020D1B3, 1'b0, 0,  4, 1, 1, 0, 0, 1'b0, 2'b00, 1'b0, 4'hD, 1'b0, 1'b0, 2'b00};
        tbl[4]  = '{32'h4030D093, 1'b0, 0,  4, 1, 1, 0, 0, 1'b0, 2'b00, 1'b1, 4'hD, 1'b0, 1'b0, 2'b00};
        tbl[5]  = '{32'h40000093, 1'b0, 0,  4, 1, 1, 0, 0, 1'b0, 2'b00, 1'b1, 4'h0, 1'b0, 1'b0, 2'b00};
        tbl[6]  = '{32'h0FF0C093, 1'b0, 0,  4, 1, 1, 0, 0, 1'b0, 2'b00, 1'b1, 4'h4, 1'b0, 1'b0, 2'b00};
        tbl[7]  = '{32'h00012083, 1'b0, 0,  5, 1, 1, 1, 0, 1'b0, 2'b00, 1'b1, 4'h0, 1'b1, 1'b0, 2'b00};
        tbl[8]  = '{32'h00012083, 1'b0, 2,  7, 1, 1, 3, 0, 1'b0, 2'b00, 1'b1, 4'h0, 1'b1, 1'b0, 2'b00};
        tbl[9]  = '{32'h00112223, 1'b0, 3,  7, 1, 0, 4, 4, 1'b0, 2'b01, 1'b1, 4'h0, 1'b0, 1'b0, 2'b00};
        tbl[10] = '{32'h00112223, 1'b0, 0,  4, 1, 0, 1, 1, 1'b0, 2'b01, 1'b1, 4'h0, 1'b0, 1'b0, 2'b00};
        tbl[11] = '{32'h00000463, 1'b1, 0,  3, 1, 0, 0, 0, 1'b1, 2'b10, 1'b0, 4'h8, 1'b0, 1'b0, 2'b00};
        tbl[12] = '{32'h00000463, 1'b0, 0,  3, 1, 0, 0, 0, 1'b0, 2'b10, 1'b0, 4'h8, 1'b0, 1'b0, 2'b00};
        tbl[13] = '{32'h00012083, 1'b0, 15, 20, 1, 1, 16, 0, 1'b0, 2'b00, 1'b1, 4'h0, 1'b1, 1'b0, 2'b00};
        tbl[14] = '{32'h00001463, 1'b1, 0,  3, 1, 0, 0, 0, 1'b1, 2'b10, 1'b0, 4'h8, 1'b0, 1'b0, 2'b00};
        ill   = '{32'h0000007F, 1'b0, 0,  3, 0, 0, 0, 0, 1'b0, 2'b00, 1'b0, 4'h0, 1'b0, 1'b1, 2'b01};
        tmo_v = '{32'h00012083, 1'b0, -1, 20, 0, 0, 16, 0, 1'b0, 2'b00, 1'b0, 4'h0, 1'b0, 1'b1, 2'b10};

        bus.imem_ready = 1'b0;
        bus.imem_rdata = '0;
        bus.dmem_ready = 1'b0;

        do_reset();
        for (int i = 0; i < 15; i++) begin
            run_instr(tbl[i], o);
            check_obs(o);
        end
`ifdef MCTRL_PERF_CNT_EN
        chk("instret_after_table", instret_cnt, 15);
`endif

        // illegal opcode: trap, then stay there with every strobe low
        run_instr(ill, o);
        check_obs(o);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            bus.imem_ready = 1'b0;
            bus.dmem_ready = 1'b0;
            #1;
            if (trap && trap_cause == CAUSE_ILLEGAL && !bus.imem_req && !bus.dmem_req
                && !pc_we && !reg_we) ok++;
        end
        chk("trap_hold_cycles", ok, 20);
        do_reset();

        // load whose dmem never answers
        run_instr(tmo_v, o);
        check_obs(o);
        do_reset();

        // reset asserted mid-MEM between clock edges
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            bus.imem_ready = bus.imem_req;
            bus.imem_rdata = 32'h00012083;
            bus.dmem_ready = 1'b0;
        end
        #1;
        chk("pre_rst_in_mem", bus.dmem_req, 1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midmem_rst_strobes", {bus.imem_req, bus.dmem_req, pc_we, reg_we}, 0);
        chk("midmem_rst_ir", ir_o, 0);
        chk("midmem_rst_trap", {trap, trap_cause}, 0);
        @(negedge clk);
        bus.imem_ready = 1'b0;
        rst = 1'b0;
        #1;
        chk("midmem_release_fetch", bus.imem_req, 1);
`ifdef MCTRL_PERF_CNT_EN
        chk("cycle_cnt_zero", cycle_cnt, 0);
        chk("instret_cnt_zero", instret_cnt, 0);
`endif
        run_instr(tbl[0], o);
        check_obs(o);
        chk("sb_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
